// File: rtl/fp16_add_arbiter.sv
// Two-requester round-robin front end for a shared LAT-cycle float16 adder, with drain control.
// Optional per-requester grant counters are built when FP16_ARB_GRANT_CNT_EN is defined.
module fp16_add_arbiter #(
    parameter int unsigned LAT = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic        req1_valid,
    output logic        req0_ready,
    output logic        req1_ready,
    input  logic [15:0] req0_a,
    input  logic [15:0] req0_b,
    input  logic [15:0] req1_a,
    input  logic [15:0] req1_b,
    output logic        rsp0_valid,
    output logic        rsp1_valid,
    output logic [15:0] rsp_data,
    output logic [15:0] add_a,
    output logic [15:0] add_b,
    input  logic [15:0] add_result,
    input  logic        drain_req,
    output logic        drain_done,
    output logic [15:0] grant_cnt0,
    output logic [15:0] grant_cnt1
);

    typedef enum logic [0:0] {StRun, StDrain} state_e;

    state_e         state_q, state_d, state_eff;
    logic           ptr_q, ptr_d, ptr_eff;
    logic [LAT-1:0] tag_vld_q, tag_vld_d;
    logic [LAT-1:0] tag_id_q, tag_id_d;
    logic           xfer;
    logic           gnt_id;

    always_comb begin
        // While rst is high the grant logic already behaves as in the reset state.
        state_eff  = rst ? StRun : state_q;
        ptr_eff    = rst ? 1'b0 : ptr_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (state_eff == StRun) begin
            if (req0_valid && (!req1_valid || !ptr_eff)) begin
                req0_ready = 1'b1;
            end else if (req1_valid && (!req0_valid || ptr_eff)) begin
                req1_ready = 1'b1;
            end
        end
        xfer   = req0_ready || req1_ready;
        gnt_id = req1_ready;

        add_a = 16'h0000;
        add_b = 16'h0000;
        if (req0_ready) begin
            add_a = req0_a;
            add_b = req0_b;
        end else if (req1_ready) begin
            add_a = req1_a;
            add_b = req1_b;
        end

        state_d = state_q;
        unique case (state_q)
            StRun:   if (drain_req)  state_d = StDrain;
            StDrain: if (!drain_req) state_d = StRun;
            default: state_d = StRun;
        endcase

        ptr_d = xfer ? ~gnt_id : ptr_q;

        tag_vld_d    = '0;
        tag_id_d     = '0;
        tag_vld_d[0] = xfer;
        tag_id_d[0]  = gnt_id;
        for (int unsigned i = 1; i < LAT; i++) begin
            tag_vld_d[i] = tag_vld_q[i-1];
            tag_id_d[i]  = tag_id_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StRun;
            ptr_q     <= 1'b0;
            tag_vld_q <= '0;
            tag_id_q  <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            tag_vld_q <= tag_vld_d;
            tag_id_q  <= tag_id_d;
        end
    end

    // Last tag stage lines up with the adder output for the op issued LAT cycles ago.
    assign rsp0_valid = !rst && tag_vld_q[LAT-1] && !tag_id_q[LAT-1];
    assign rsp1_valid = !rst && tag_vld_q[LAT-1] && tag_id_q[LAT-1];
    assign rsp_data   = add_result;
    assign drain_done = !rst && (state_q == StDrain) && (tag_vld_q == '0);

`ifdef FP16_ARB_GRANT_CNT_EN
    logic [15:0] cnt0_q, cnt1_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt0_q <= 16'h0000;
            cnt1_q <= 16'h0000;
        end else begin
            if (req0_ready && (cnt0_q != 16'hFFFF)) cnt0_q <= cnt0_q + 16'd1;
            if (req1_ready && (cnt1_q != 16'hFFFF)) cnt1_q <= cnt1_q + 16'd1;
        end
    end

    assign grant_cnt0 = cnt0_q;
    assign grant_cnt1 = cnt1_q;
`else
    assign grant_cnt0 = 16'h0000;
    assign grant_cnt1 = 16'h0000;
`endif

endmodule

// File: tb/tb_fp16_add_arbiter.sv
// Randomised self-checking bench for fp16_add_arbiter with a behavioural float16 adder
// and a queue-based reference model of grants, responses and drain.
module tb_fp16_add_arbiter;

    localparam int unsigned LAT = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [15:0] req0_a, req0_b, req1_a, req1_b;
    logic        rsp0_valid, rsp1_valid;
    logic [15:0] rsp_data, add_a, add_b, add_result;
    logic        drain_req, drain_done;
    logic [15:0] grant_cnt0, grant_cnt1;

    always #5 clk = ~clk;

    fp16_add_arbiter #(.LAT(LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req1_valid (req1_valid),
        .req0_ready (req0_ready),
        .req1_ready (req1_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp0_valid (rsp0_valid),
        .rsp1_valid (rsp1_valid),
        .rsp_data   (rsp_data),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_result (add_result),
        .drain_req  (drain_req),
        .drain_done (drain_done),
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1)
    );

    function automatic real h2r(logic [15:0] h);
        real v;
        int  e;
        e = int'(h[14:10]);
        if (e == 0) v = real'(h[9:0]) * (2.0 ** -24);
        else        v = (1.0 + real'(h[9:0]) / 1024.0) * (2.0 ** (e - 15));
        return h[15] ? -v : v;
    endfunction

    function automatic logic [15:0] r2h(real x);
        real         ax;
        int          e, m;
        logic [15:0] h;
        if (x == 0.0) return 16'h0000;
        ax = (x < 0.0) ? -x : x;
        e  = 0;
        while (ax >= 2.0) begin ax = ax / 2.0; e++; end
        while (ax < 1.0)  begin ax = ax * 2.0; e--; end
        if (e < -14) return 16'h0000;
        m = $rtoi((ax - 1.0) * 1024.0 + 0.5);
        if (m == 1024) begin m = 0; e++; end
        h[15]    = (x < 0.0);
        h[14:10] = 5'(e + 15);
        h[9:0]   = 10'(m);
        return h;
    endfunction

    function automatic logic [15:0] rnd_h();
        logic [15:0] h;
        h[15]    = 1'($urandom);
        h[14:10] = 5'($urandom_range(10, 20));
        h[9:0]   = 10'($urandom);
        return h;
    endfunction

    // Shared float16 adder with LAT cycles of latency.
    logic [15:0] apipe [LAT];
    always @(posedge clk) begin
        apipe[0] <= r2h(h2r(add_a) + h2r(add_b));
        for (int i = 1; i < LAT; i++) apipe[i] <= apipe[i-1];
    end
    assign add_result = apipe[LAT-1];

    typedef struct {
        bit  id;
        int  due;
        real sum;
    } ent_t;

    ent_t        q[$];
    int          cyc = 0;
    bit          m_drain = 1'b0;
    bit          m_ptr = 1'b0;
    int          m_cnt0 = 0, m_cnt1 = 0;
    int          n_xfer0 = 0, n_xfer1 = 0, n_rsp0 = 0, n_rsp1 = 0;
    logic [15:0] last_rsp = 16'h0000;
    int          n_checks = 0, n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock cycle: check outputs at the falling edge, then advance the model at the rising edge.
    task automatic step();
        bit          e0, e1, run, ptr, have, hid;
        logic [15:0] ea, eb;
        real         d;
        @(negedge clk);
        run = rst ? 1'b1 : !m_drain;
        ptr = rst ? 1'b0 : m_ptr;
        e0  = 1'b0;
        e1  = 1'b0;
        if (run) begin
            if (req0_valid && req1_valid) begin
                if (ptr) e1 = 1'b1; else e0 = 1'b1;
            end else if (req0_valid) e0 = 1'b1;
            else if (req1_valid) e1 = 1'b1;
        end
        ea = e0 ? req0_a : (e1 ? req1_a : 16'h0000);
        eb = e0 ? req0_b : (e1 ? req1_b : 16'h0000);
        check_eq("req0_ready", req0_ready, e0);
        check_eq("req1_ready", req1_ready, e1);
        check_eq("add_a", add_a, ea);
        check_eq("add_b", add_b, eb);

        have = !rst && (q.size() > 0) && (q[0].due == cyc);
        hid  = have ? q[0].id : 1'b0;
        check_eq("drain_done", drain_done, !rst && m_drain && (q.size() == 0));
        check_eq("rsp0_valid", rsp0_valid, have && !hid);
        check_eq("rsp1_valid", rsp1_valid, have && hid);
        if (have) begin
            d = h2r(rsp_data) - q[0].sum;
            check_eq("rsp_data_tol", (d <= 0.2 && d >= -0.2), 1);
            void'(q.pop_front());
        end
        if (rsp0_valid) begin n_rsp0++; last_rsp = rsp_data; end
        if (rsp1_valid) begin n_rsp1++; last_rsp = rsp_data; end
`ifdef FP16_ARB_GRANT_CNT_EN
        check_eq("grant_cnt0", grant_cnt0, m_cnt0);
        check_eq("grant_cnt1", grant_cnt1, m_cnt1);
`else
        check_eq("grant_cnt0", grant_cnt0, 0);
        check_eq("grant_cnt1", grant_cnt1, 0);
`endif

        @(posedge clk);
        if (rst) begin
            q.delete();
            m_drain = 1'b0;
            m_ptr   = 1'b0;
            m_cnt0  = 0;
            m_cnt1  = 0;
        end else begin
            if (e0 || e1) begin
                q.push_back('{id: e1, due: cyc + LAT, sum: h2r(ea) + h2r(eb)});
                m_ptr = ~e1;
                if (e0) begin n_xfer0++; if (m_cnt0 < 65535) m_cnt0++; end
                if (e1) begin n_xfer1++; if (m_cnt1 < 65535) m_cnt1++; end
            end
            m_drain = drain_req;
        end
        cyc++;
        #1;
    endtask

    task automatic set_req(input bit v0, input bit v1);
        req0_valid = v0;
        req1_valid = v1;
        req0_a     = rnd_h();
        req0_b     = rnd_h();
        req1_a     = rnd_h();
        req1_b     = rnd_h();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_req(1'b0, 1'b0);
        step();
        rst = 1'b0;
    endtask

    int b0, b1, x0, x1;

    initial begin
        rst       = 1'b1;
        drain_req = 1'b0;
        // Both valid while in reset: req0 must win from the reset pointer.
        set_req(1'b1, 1'b1);
        step();
        do_reset();

        // Single requester 1.0 + 2.0.
        set_req(1'b1, 1'b0);
        req0_a = 16'h3C00;
        req0_b = 16'h4000;
        b0 = n_rsp0;
        b1 = n_rsp1;
        step();
        set_req(1'b0, 1'b0);
        repeat (LAT) step();
        check_eq("single_rsp0_cnt", n_rsp0 - b0, 1);
        check_eq("single_rsp1_cnt", n_rsp1 - b1, 0);
        check_eq("single_data", last_rsp, 16'h4200);

        // Both valid for six cycles after reset: strict alternation.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            set_req(1'b1, 1'b1);
            step();
        end
        set_req(1'b0, 1'b0);
        repeat (LAT + 1) step();
`ifdef FP16_ARB_GRANT_CNT_EN
        check_eq("alt_cnt0", grant_cnt0, 3);
        check_eq("alt_cnt1", grant_cnt1, 3);
`else
        check_eq("alt_cnt0", grant_cnt0, 0);
        check_eq("alt_cnt1", grant_cnt1, 0);
`endif

        // Drain: three ops, then drain raised alongside a still-pending grant.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_req(1'b1, 1'b0);
            step();
        end
        drain_req = 1'b1;
        set_req(1'b1, 1'b1);
        step();
        for (int i = 0; i < LAT + 2; i++) begin
            set_req(1'b1, 1'b1);
            step();
        end
        check_eq("drain_done_final", drain_done, 1);
        drain_req = 1'b0;
        set_req(1'b1, 1'b1);
        step();
        check_eq("drain_resume", req0_ready | req1_ready, 1);
        step();

        // Reset with four ops in flight discards them.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_req(1'b1, 1'b1);
            step();
        end
        b0 = n_rsp0;
        b1 = n_rsp1;
        do_reset();
        repeat (LAT) step();
        check_eq("flush_rsp0", n_rsp0 - b0, 0);
        check_eq("flush_rsp1", n_rsp1 - b1, 0);
        set_req(1'b1, 1'b1);
        #1;
        check_eq("flush_ptr0", req0_ready, 1);
        step();
        set_req(1'b0, 1'b0);
        repeat (LAT + 1) step();

        // Random traffic.
        b0 = n_rsp0;
        b1 = n_rsp1;
        x0 = n_xfer0;
        x1 = n_xfer1;
        for (int i = 0; i < 1000; i++) begin
            set_req($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
            step();
        end
        set_req(1'b0, 1'b0);
        repeat (LAT + 1) step();
        check_eq("rand_count0", n_rsp0 - b0, n_xfer0 - x0);
        check_eq("rand_count1", n_rsp1 - b1, n_xfer1 - x1);

`ifdef FP16_ARB_GRANT_CNT_EN
        do_reset();
        for (int i = 0; i < 65540; i++) begin
            set_req(1'b1, 1'b0);
            step();
        end
        check_eq("cnt0_saturate", grant_cnt0, 16'hFFFF);
        set_req(1'b0, 1'b0);
        repeat (LAT + 1) step();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
